ks_xor_cipher: RTL
==================

# ks_xor_cipher

Downstream consumer of the Massey-Rueppel keystream generator: packs the generator's serial keystream bits into DATA_W-bit words, buffers them in a small FIFO and XORs them with plaintext words under a valid/ready handshake, emitting ciphertext. The generator cannot be stalled, so keystream words that arrive with the buffer full are dropped and flagged. Encryption and decryption are the same operation.

## Interface
- DATA_W, 8, width of plaintext/ciphertext/keystream word
- KS_DEPTH, 2, keystream word FIFO depth (≥1)

- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_clr  in  1  synchronous clear: empties packer, FIFO and output register; clears o_overrun
- i_ks_bit  in  1  keystream bit from generator
- i_ks_valid  in  1  one-cycle strobe: i_ks_bit is a new keystream bit (one per generator step)
- i_pt_data  in  DATA_W  plaintext word
- i_pt_valid  in  1  plaintext valid
- o_pt_ready  out  1  plaintext accepted when valid&ready
- o_ct_data  out  DATA_W  ciphertext word
- o_ct_valid  out  1  ciphertext valid
- i_ct_ready  in  1  downstream ready
- o_ks_level  out  $clog2(KS_DEPTH+1)  keystream words buffered
- o_overrun  out  1  sticky: a completed keystream word was dropped

## Operation
- Packer: shift register + bit counter 0..DATA_W-1. On i_ks_valid, bit shifts in; first bit of a word lands in MSB. On the DATA_W-th bit the word is pushed into the FIFO and the counter wraps to 0.
- FIFO full at completion with no pop in the same cycle: word dropped, o_overrun set (stays 1 until i_rst or i_clr). Push and pop in the same cycle with FIFO full: push succeeds, level unchanged.
- o_pt_ready = (o_ks_level != 0) && (!o_ct_valid || i_ct_ready). Combinational; does not depend on i_pt_valid.
- Plaintext accept: pops FIFO head, loads o_ct_data = i_pt_data ^ head, sets o_ct_valid.
- Output register: o_ct_data/o_ct_valid held stable while o_ct_valid && !i_ct_ready. Cleared on transfer unless a new accept occurs in the same cycle (back-to-back, full throughput).
- A word completing in cycle N is not poppable until N+1 (no packer→output bypass).
- i_clr has priority over all same-cycle events; bits/plaintext presented in that cycle are discarded.

## Timing
- Reset (i_rst=1): counter 0, FIFO empty, o_ct_data=0, o_ct_valid=0, o_pt_ready=0, o_ks_level=0, o_overrun=0. Takes effect immediately, mid-word or mid-handshake; partial word discarded.
- Plaintext latency: accepted at edge N → o_ct_valid=1 after edge N (visible cycle N+1).
- Keystream latency: DATA_W-th strobe at edge N → o_ks_level increments after edge N; o_pt_ready may assert in cycle N+1.
- Throughput: one word per cycle while keystream is available and i_ct_ready=1.
- i_ks_valid gaps of any length are allowed; counter holds.

## Structure
- Package ks_cipher_pkg: default DATA_W, KS_DEPTH constants, level-width function.
- Sub-module ks_fifo (synchronous FIFO, DATA_W × KS_DEPTH, push/pop/full/empty/level, async active-high reset); packer and output register live in top.

## Test plan
- Reset then bits 1,0,1,0,0,1,0,1 on strobes → o_ks_level=1, o_pt_ready=1; plaintext 0x3C → next cycle o_ct_data=0x99, o_ct_valid=1.
- 24 bits (three words), no plaintext, KS_DEPTH=2 → o_ks_level=2, o_overrun=1 after 24th bit, first two words retained in order.
- Word buffered, i_ct_ready=0 two cycles after accept → o_ct_data stable, o_pt_ready=0 while second word buffered; i_ct_ready=1 → transfer and new accept same cycle.
- Two words buffered, plaintext valid every cycle, i_ct_ready=1 → two ciphertexts on consecutive cycles, then o_pt_ready=0.
- FIFO full, 8th bit completes in same cycle as pop → level stays 2, o_overrun stays 0.
- i_rst pulse after 5 bits, then 8 bits 0xFF → level=1, word 0xFF (partial bits discarded); i_clr mid-word gives identical result.

Source files
------------

// File: rtl/ks_cipher_pkg.sv
// Shared defaults and helpers for the keystream XOR cipher.
// Level counters need one more state than the depth, so that width is derived here.
package ks_cipher_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int KS_DEPTH_DEF = 2;

  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ks_fifo.sv
// Small synchronous FIFO buffering packed keystream words.
// When full, a push is accepted only if a pop happens in the same cycle.
module ks_fifo
  import ks_cipher_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = KS_DEPTH_DEF,
  localparam int LVL_W = levelWidth(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_pushData,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_headData,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [LVL_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == LVL_W'(DEPTH));
  assign o_level    = r_count;
  assign o_headData = r_mem[r_rdPtr];
  assign w_doPop    = i_pop && !o_empty && !i_clr;
  assign w_doPush   = i_push && !i_clr && (!o_full || w_doPop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries below the level are ever read.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/ks_xor_cipher.sv
// Packs serial keystream bits into words, buffers them, and XORs them with
// plaintext under valid/ready; the same operation encrypts and decrypts.
module ks_xor_cipher
  import ks_cipher_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int KS_DEPTH = KS_DEPTH_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clr,
  input  logic                              i_ks_bit,
  input  logic                              i_ks_valid,
  input  logic [DATA_W-1:0]                 i_pt_data,
  input  logic                              i_pt_valid,
  output logic                              o_pt_ready,
  output logic [DATA_W-1:0]                 o_ct_data,
  output logic                              o_ct_valid,
  input  logic                              i_ct_ready,
  output logic [levelWidth(KS_DEPTH)-1:0]   o_ks_level,
  output logic                              o_overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LVL_W = levelWidth(KS_DEPTH);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [DATA_W-1:0] w_word;
  logic              w_wordDone;
  logic              w_accept;
  logic              w_transfer;
  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [LVL_W-1:0]  w_level;

  assign w_word     = {r_shift[DATA_W-2:0], i_ks_bit};
  assign w_wordDone = i_ks_valid && !i_clr && (r_bitCnt == CNT_W'(DATA_W - 1));
  assign o_pt_ready = !w_empty && (!o_ct_valid || i_ct_ready);
  assign w_accept   = i_pt_valid && o_pt_ready && !i_clr;
  assign w_transfer = o_ct_valid && i_ct_ready;
  assign o_ks_level = w_level;

  ks_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (KS_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (i_clr),
    .i_push     (w_wordDone),
    .i_pushData (w_word),
    .i_pop      (w_accept),
    .o_headData (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  // First bit of each word ends up in the MSB after DATA_W shifts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (i_clr) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else if (i_ks_valid) begin
      r_shift  <= w_word;
      r_bitCnt <= w_wordDone ? '0 : r_bitCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overrun <= 1'b0;
    end else if (i_clr) begin
      o_overrun <= 1'b0;
    end else if (w_wordDone && w_full && !w_accept) begin
      o_overrun <= 1'b1;
    end
  end

  // A new accept on the transfer cycle keeps the output full every cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ct_data  <= '0;
      o_ct_valid <= 1'b0;
    end else if (i_clr) begin
      o_ct_data  <= '0;
      o_ct_valid <= 1'b0;
    end else if (w_accept) begin
      o_ct_data  <= i_pt_data ^ w_head;
      o_ct_valid <= 1'b1;
    end else if (w_transfer) begin
      o_ct_data  <= '0;
      o_ct_valid <= 1'b0;
    end
  end

endmodule
